wt_dcache_mem_responder: RTL and testbench
==========================================

Name: wt_dcache_mem_responder

Overview:
- Memory-side responder for the write-through data cache's memory request interface, as used on the L1.5 NoC configuration.
- Accepts one load or store request per cycle, tagged with a transaction ID.
- Services it against an internal word-addressed backing store.
- Returns a tagged response (load line fill or store acknowledge) after a fixed pipeline latency, through a bounded response FIFO.
- Used as the far end of the cache's memory port in standalone core/cache testbenches and small FPGA images without a real L2.

Parameters:
- MemTidWidth, 2, width of request/response transaction ID.
- AddrWidth, 64, physical address width.
- DataWidth, 64, request write-data width (one word).
- LineWidth, 128, response data width (one cache line).
- MemWords, 256, number of DataWidth words in the backing store (power of two).
- Latency, 2, cycles from request acceptance to response entering the FIFO (≥1).
- RespDepth, 4, response FIFO depth; also the outstanding-request limit.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  request accepted this cycle when valid&ready
- req_store_i  in  1  1 = store, 0 = load
- req_paddr_i  in  AddrWidth  physical address
- req_wdata_i  in  DataWidth  store data
- req_be_i  in  DataWidth/8  store byte enables
- req_tid_i  in  MemTidWidth  transaction ID
- rtrn_valid_o  out  1  response valid
- rtrn_ready_i  in  1  response consumed when valid&ready
- rtrn_store_o  out  1  1 = store ack, 0 = load return
- rtrn_tid_o  out  MemTidWidth  echoed ID
- rtrn_data_o  out  LineWidth  line data (zero for store acks)
- outstanding_o  out  $clog2(RespDepth+1)  in-pipe plus in-FIFO count

Behaviour:
- Reset (asynchronous, rst_ni low): all outputs 0; pipeline valids, FIFO pointers and count cleared; backing store cleared to zero. Requests in flight at reset are dropped with no response.
- Acceptance: req_ready_o = (outstanding_o < RespDepth). Combinational from state only, never from req_valid_i.
- Outstanding accounting: outstanding increments on accept and decrements on response handshake. Simultaneous accept and pop leaves it unchanged.
- Word index: req_paddr_i[3 +: log2(MemWords)]. Higher address bits are ignored, so addresses wrap modulo MemWords*8 bytes.
- Store:
  - On the accept cycle, each byte i with req_be_i[i]=1 is written from req_wdata_i into the indexed word; other bytes are unchanged.
  - Response: store=1, tid echoed, data=0.
- Load:
  - The line index is the word index with bit 0 cleared.
  - The full line is read on the accept cycle: {word[idx|1], word[idx&~1]}, with the low word in bits [63:0].
  - Response: store=0, tid echoed.
- Ordering:
  - A load accepted the cycle after a store to the same word sees the stored data.
  - Responses leave strictly in acceptance order.
- Latency pipeline: Latency-stage shift register of {valid, store, tid, data}, advancing every cycle. An accepted request enters the FIFO exactly Latency cycles later. The FIFO never overflows, because of the outstanding limit.
- Response output:
  - FIFO head is driven onto rtrn_*; rtrn_valid_o = FIFO non-empty.
  - Data is held stable while valid&!ready.
  - Minimum accept-to-rtrn_valid latency is Latency cycles.
  - Back-to-back accepts with ready held high yield one response per cycle.
- FIFO boundaries:
  - Empty with an arriving entry: no bypass; it appears the next cycle.
  - Full FIFO and full pipeline are impossible by construction.
  - Pointers wrap modulo RespDepth.

Optional Feature:
- Macro: WT_DCACHE_MEM_RESPONDER_BIG_ENDIAN_EN.
- When defined: rtrn_data_o is byte-swapped within each 64-bit word, matching the big-endian L1.5 NoC. Store write data and byte enables are also byte-reversed before writing, so a store then load round-trip is value-preserving.
- When undefined: little-endian, no swapping.

Test Plan:
- Reset, then a single load tid=1 at 0x80 with rtrn_ready high -> rtrn_valid exactly 2 cycles after accept, tid=1, store=0, data=0.
- Store 0xDEADBEEF_CAFEF00D be=0xFF at 0x88 tid=2, then load 0x80 tid=3 -> store ack tid=2 data=0, then load data[127:64]=0xDEADBEEF_CAFEF00D, data[63:0]=0.
- Store be=0x0F data 0x11223344_55667788 to a zeroed word -> subsequent load returns 0x00000000_55667788 in that word.
- rtrn_ready held low, 6 back-to-back requests -> exactly 4 accepted, req_ready low afterwards, outstanding_o=4. Releasing ready drains tids in order, and req_ready reasserts the cycle after the first pop.
- Address 0x800+0x10 (MemWords=256) -> aliases to word 2; a store there is visible from a load at 0x10.
- Assert rst_ni low mid-stream with 3 outstanding -> outputs 0 immediately; no stale responses after release; earlier stored data reads as 0.

Source files
------------

// File: rtl/wt_dcache_mem_responder.sv
// wt_dcache_mem_responder: tagged load/store responder over a word-addressed backing store, fixed latency, bounded FIFO.
// Optional WT_DCACHE_MEM_RESPONDER_BIG_ENDIAN_EN byte-swaps store data/enables and returned line words.
module wt_dcache_mem_responder #(
  parameter int unsigned MemTidWidth = 2,
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned LineWidth   = 128,
  parameter int unsigned MemWords    = 256,
  parameter int unsigned Latency     = 2,
  parameter int unsigned RespDepth   = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic                              req_store_i,
  input  logic [AddrWidth-1:0]              req_paddr_i,
  input  logic [DataWidth-1:0]              req_wdata_i,
  input  logic [DataWidth/8-1:0]            req_be_i,
  input  logic [MemTidWidth-1:0]            req_tid_i,
  output logic                              rtrn_valid_o,
  input  logic                              rtrn_ready_i,
  output logic                              rtrn_store_o,
  output logic [MemTidWidth-1:0]            rtrn_tid_o,
  output logic [LineWidth-1:0]              rtrn_data_o,
  output logic [$clog2(RespDepth+1)-1:0]    outstanding_o
);
  localparam int unsigned IdxW      = $clog2(MemWords);
  localparam int unsigned NBytes    = DataWidth / 8;
  localparam int unsigned OffW      = $clog2(NBytes);
  localparam int unsigned LineWords = LineWidth / DataWidth;
  localparam int unsigned CntW      = $clog2(RespDepth + 1);
  localparam int unsigned PtrW      = (RespDepth > 1) ? $clog2(RespDepth) : 1;

  typedef struct packed {
    logic                   store;
    logic [MemTidWidth-1:0] tid;
    logic [LineWidth-1:0]   data;
  } ent_t;

`ifdef WT_DCACHE_MEM_RESPONDER_BIG_ENDIAN_EN
  function automatic logic [DataWidth-1:0] bswap(input logic [DataWidth-1:0] w);
    for (int b = 0; b < NBytes; b++) bswap[8*b +: 8] = w[DataWidth-8-8*b +: 8];
  endfunction
  function automatic logic [NBytes-1:0] brev(input logic [NBytes-1:0] e);
    for (int b = 0; b < NBytes; b++) brev[b] = e[NBytes-1-b];
  endfunction
`endif

  function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
    inc = (p == PtrW'(RespDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [DataWidth-1:0] mem_q [MemWords];
  logic [DataWidth-1:0] mem_d [MemWords];
  ent_t                 fifo_q [RespDepth];
  ent_t                 fifo_d [RespDepth];
  logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]      fcnt_q, fcnt_d, cnt_q, cnt_d;
  logic [IdxW-1:0]      idx, base;
  logic [DataWidth-1:0] wdat;
  logic [NBytes-1:0]    bes;
  logic [LineWidth-1:0] line;
  logic                 accept, pop, push_valid;
  ent_t                 new_ent, push_ent, head;
  logic                 unused_addr;

  assign unused_addr   = ^{req_paddr_i[AddrWidth-1:OffW+IdxW], req_paddr_i[OffW-1:0]};
  assign req_ready_o   = rst_ni && (cnt_q < CntW'(RespDepth));
  assign accept        = req_valid_i && req_ready_o;
  assign rtrn_valid_o  = fcnt_q != '0;
  assign pop           = rtrn_valid_o && rtrn_ready_i;
  assign head          = fifo_q[rptr_q];
  assign rtrn_store_o  = head.store;
  assign rtrn_tid_o    = head.tid;
  assign rtrn_data_o   = head.data;
  assign outstanding_o = cnt_q;

  always_comb begin
    idx  = req_paddr_i[OffW +: IdxW];
    base = idx & ~IdxW'(LineWords - 1);
`ifdef WT_DCACHE_MEM_RESPONDER_BIG_ENDIAN_EN
    wdat = bswap(req_wdata_i);
    bes  = brev(req_be_i);
`else
    wdat = req_wdata_i;
    bes  = req_be_i;
`endif
    line = '0;
    for (int w = 0; w < LineWords; w++) begin
`ifdef WT_DCACHE_MEM_RESPONDER_BIG_ENDIAN_EN
      line[w*DataWidth +: DataWidth] = bswap(mem_q[base | IdxW'(w)]);
`else
      line[w*DataWidth +: DataWidth] = mem_q[base | IdxW'(w)];
`endif
    end
    new_ent.store = req_store_i;
    new_ent.tid   = req_tid_i;
    new_ent.data  = req_store_i ? '0 : line;
    for (int i = 0; i < MemWords; i++) mem_d[i] = mem_q[i];
    for (int b = 0; b < NBytes; b++)
      if (accept && req_store_i && bes[b]) mem_d[idx][8*b +: 8] = wdat[8*b +: 8];
  end

  // the final pipeline stage writes the FIFO, so it is combinational when Latency is 1
  if (Latency > 1) begin : g_pipe
    logic pv_q [Latency-1];
    logic pv_d [Latency-1];
    ent_t pe_q [Latency-1];
    ent_t pe_d [Latency-1];
    always_comb begin
      pv_d[0] = accept;
      pe_d[0] = new_ent;
      for (int k = 1; k < Latency - 1; k++) begin
        pv_d[k] = pv_q[k-1];
        pe_d[k] = pe_q[k-1];
      end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int k = 0; k < Latency - 1; k++) begin
          pv_q[k] <= 1'b0;
          pe_q[k] <= '0;
        end
      end else begin
        pv_q <= pv_d;
        pe_q <= pe_d;
      end
    end
    assign push_valid = pv_q[Latency-2];
    assign push_ent   = pe_q[Latency-2];
  end else begin : g_nopipe
    assign push_valid = accept;
    assign push_ent   = new_ent;
  end

  always_comb begin
    for (int i = 0; i < RespDepth; i++) fifo_d[i] = fifo_q[i];
    if (push_valid) fifo_d[wptr_q] = push_ent;
    wptr_d = push_valid ? inc(wptr_q) : wptr_q;
    rptr_d = pop ? inc(rptr_q) : rptr_q;
    fcnt_d = fcnt_q + CntW'(push_valid) - CntW'(pop);
    cnt_d  = cnt_q + CntW'(accept) - CntW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MemWords; i++) mem_q[i] <= '0;
      for (int i = 0; i < RespDepth; i++) fifo_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      fifo_q <= fifo_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fcnt_q <= fcnt_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_wt_dcache_mem_responder.sv
// tb_wt_dcache_mem_responder: directed checks of latency, store/load data, backpressure, aliasing and reset.
module tb_wt_dcache_mem_responder;
  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic         req_store_i = 1'b0;
  logic [63:0]  req_paddr_i = '0;
  logic [63:0]  req_wdata_i = '0;
  logic [7:0]   req_be_i = '0;
  logic [1:0]   req_tid_i = '0;
  logic         rtrn_valid_o;
  logic         rtrn_ready_i = 1'b1;
  logic         rtrn_store_o;
  logic [1:0]   rtrn_tid_o;
  logic [127:0] rtrn_data_o;
  logic [2:0]   outstanding_o;
  int           n_cmp = 0;
  int           n_err = 0;
  wt_dcache_mem_responder dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_store_i(req_store_i),
    .req_paddr_i(req_paddr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i), .req_tid_i(req_tid_i),
    .rtrn_valid_o(rtrn_valid_o), .rtrn_ready_i(rtrn_ready_i), .rtrn_store_o(rtrn_store_o),
    .rtrn_tid_o(rtrn_tid_o), .rtrn_data_o(rtrn_data_o), .outstanding_o(outstanding_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic drive(input logic st, input logic [63:0] a, input logic [63:0] d, input logic [7:0] be, input logic [1:0] tid);
    req_valid_i = 1'b1;
    req_store_i = st;
    req_paddr_i = a;
    req_wdata_i = d;
    req_be_i    = be;
    req_tid_i   = tid;
  endtask
  task automatic idle;
    req_valid_i = 1'b0;
    req_store_i = 1'b0;
  endtask
  initial begin
    #100000;
    n_err++;
    $error("FAIL timeout: test did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #1;
    chk("rst_ready", req_ready_o, 1'b0);
    chk("rst_valid", rtrn_valid_o, 1'b0);
    chk("rst_outstanding", outstanding_o, 3'd0);
    chk("rst_data", rtrn_data_o, 128'h0);
    tick;
    tick;
    rst_ni = 1'b1;
    tick;
    drive(1'b0, 64'h80, 64'h0, 8'h00, 2'd1);
    chk("s1_ready", req_ready_o, 1'b1);
    tick;
    idle;
    chk("s1_lat1_valid", rtrn_valid_o, 1'b0);
    chk("s1_outstanding", outstanding_o, 3'd1);
    tick;
    chk("s1_valid", rtrn_valid_o, 1'b1);
    chk("s1_tid", rtrn_tid_o, 2'd1);
    chk("s1_store", rtrn_store_o, 1'b0);
    chk("s1_data", rtrn_data_o, 128'h0);
    tick;
    chk("s1_empty", rtrn_valid_o, 1'b0);
    chk("s1_out0", outstanding_o, 3'd0);
    drive(1'b1, 64'h88, 64'hDEADBEEF_CAFEF00D, 8'hFF, 2'd2);
    tick;
    drive(1'b0, 64'h80, 64'h0, 8'h00, 2'd3);
    tick;
    idle;
    chk("s2_ack_valid", rtrn_valid_o, 1'b1);
    chk("s2_ack_store", rtrn_store_o, 1'b1);
    chk("s2_ack_tid", rtrn_tid_o, 2'd2);
    chk("s2_ack_data", rtrn_data_o, 128'h0);
    tick;
    chk("s2_ld_tid", rtrn_tid_o, 2'd3);
    chk("s2_ld_store", rtrn_store_o, 1'b0);
    chk("s2_ld_data", rtrn_data_o, 128'hDEADBEEF_CAFEF00D_00000000_00000000);
    tick;
    drive(1'b1, 64'h100, 64'h11223344_55667788, 8'h0F, 2'd0);
    tick;
    drive(1'b0, 64'h100, 64'h0, 8'h00, 2'd1);
    tick;
    idle;
    chk("s3_ack_tid", rtrn_tid_o, 2'd0);
    tick;
    chk("s3_ld_data", rtrn_data_o, 128'h00000000_00000000_00000000_55667788);
    tick;
    rtrn_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 64'h80, 64'h0, 8'h00, 2'(i));
      chk("s4_ready", req_ready_o, 128'(i < 4));
      tick;
    end
    idle;
    chk("s4_outstanding", outstanding_o, 3'd4);
    chk("s4_ready_low", req_ready_o, 1'b0);
    chk("s4_head_tid", rtrn_tid_o, 2'd0);
    tick;
    chk("s4_hold_valid", rtrn_valid_o, 1'b1);
    chk("s4_hold_tid", rtrn_tid_o, 2'd0);
    chk("s4_hold_data", rtrn_data_o, 128'hDEADBEEF_CAFEF00D_00000000_00000000);
    rtrn_ready_i = 1'b1;
    chk("s4_ready_before_pop", req_ready_o, 1'b0);
    tick;
    chk("s4_ready_after_pop", req_ready_o, 1'b1);
    chk("s4_out3", outstanding_o, 3'd3);
    chk("s4_tid1", rtrn_tid_o, 2'd1);
    tick;
    chk("s4_tid2", rtrn_tid_o, 2'd2);
    tick;
    chk("s4_tid3", rtrn_tid_o, 2'd3);
    tick;
    chk("s4_drained", rtrn_valid_o, 1'b0);
    chk("s4_out0", outstanding_o, 3'd0);
    drive(1'b1, 64'h810, 64'h01234567_89ABCDEF, 8'hFF, 2'd2);
    tick;
    drive(1'b0, 64'h10, 64'h0, 8'h00, 2'd3);
    tick;
    idle;
    chk("s5_ack_store", rtrn_store_o, 1'b1);
    tick;
    chk("s5_ld_tid", rtrn_tid_o, 2'd3);
    chk("s5_ld_data", rtrn_data_o, 128'h00000000_00000000_01234567_89ABCDEF);
    tick;
    rtrn_ready_i = 1'b0;
    for (int i = 1; i < 4; i++) begin
      drive(1'b0, 64'h88, 64'h0, 8'h00, 2'(i));
      tick;
    end
    idle;
    chk("s6_out3", outstanding_o, 3'd3);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("s6_rst_valid", rtrn_valid_o, 1'b0);
    chk("s6_rst_out", outstanding_o, 3'd0);
    chk("s6_rst_ready", req_ready_o, 1'b0);
    chk("s6_rst_tid", rtrn_tid_o, 2'd0);
    chk("s6_rst_data", rtrn_data_o, 128'h0);
    tick;
    rst_ni = 1'b1;
    rtrn_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("s6_no_stale", rtrn_valid_o, 1'b0);
    end
    drive(1'b0, 64'h80, 64'h0, 8'h00, 2'd0);
    tick;
    drive(1'b0, 64'h10, 64'h0, 8'h00, 2'd1);
    tick;
    idle;
    chk("s6_ld1_valid", rtrn_valid_o, 1'b1);
    chk("s6_ld1_data", rtrn_data_o, 128'h0);
    tick;
    chk("s6_ld2_tid", rtrn_tid_o, 2'd1);
    chk("s6_ld2_data", rtrn_data_o, 128'h0);
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
